pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush, bubble-safe control gating and a saturating back-pressure counter. It replaces the fixed-width, always-advancing inter-stage registers (EX/MEM, MEM/WB, and similar) with one reusable block. The stage is placed between any two core stages. Payload and control fields are flattened into two buses by the instantiating stage.

---
 rtl/pipe_stage_reg.sv | 181 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, flush, bubble-gated control, saturating stall counter.
// Latency 1 cycle. Default build is a single entry with combinational in_ready; PIPE_STAGE_SKID_EN selects a two-entry skid with registered in_ready.
module pipe_stage_reg #(
   parameter int unsigned       DATA_W   = 64,
   parameter int unsigned       CTRL_W   = 8,
   parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}},
   parameter int unsigned       CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic in_xfer;
   logic out_xfer;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              valid_q, valid_d;
   logic              rdy_q, rdy_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

   // in_ready depends only on registered state and flush, never on out_ready.
   assign in_ready  = !flush && rdy_q;
   assign out_valid = valid_q;
   assign out_data  = main_data_q;
   assign out_ctrl  = main_ctrl_q;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  state_d     = ST_BUSY;
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end
            end
            ST_BUSY: begin
               if (in_xfer && out_xfer) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end else if (in_xfer) begin
                  state_d     = ST_FULL;
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
               end else if (out_xfer) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_xfer) begin
                  state_d     = ST_BUSY;
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      valid_d = (state_d != ST_EMPTY);
      rdy_d   = (state_d != ST_FULL);
      if (!valid_d) begin
         main_ctrl_d = CTRL_RST;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         valid_q     <= 1'b0;
         rdy_q       <= 1'b1;
         main_data_q <= '0;
         main_ctrl_q <= CTRL_RST;
         skid_data_q <= '0;
         skid_ctrl_q <= CTRL_RST;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         rdy_q       <= rdy_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
      end
   end
`else
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;

   // The slot frees up in the same cycle downstream takes it.
   assign in_ready  = !flush && (!valid_q || out_ready);
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_ctrl  = ctrl_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (in_xfer) begin
         valid_d = 1'b1;
         data_d  = in_data;
         ctrl_d  = in_ctrl;
      end else if (out_xfer) begin
         valid_d = 1'b0;
      end
      if (!valid_d) begin
         ctrl_d = CTRL_RST;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= CTRL_RST;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
      end
   end
`endif

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign stall_cnt = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (out_valid && !out_ready && !flush && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed phases plus random traffic against a queue-based reference model.
module tb_pipe_stage_reg;

   localparam logic [7:0] C_RST   = 8'h30;
   localparam int         CNT_MAX = 15;
`ifdef PIPE_STAGE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  c;
   } ent_t;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic [7:0]  in_ctrl;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [7:0]  out_ctrl;
   logic        cnt_clr;
   logic [3:0]  stall_cnt;

   int          errors = 0;
   int          checks = 0;
   int          n_acc  = 0;
   ent_t        mq[$];
   int          m_cnt  = 0;
   logic [63:0] m_head = '0;

   pipe_stage_reg #(
      .DATA_W  (64),
      .CTRL_W  (8),
      .CTRL_RST(C_RST),
      .CNT_W   (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_ctrl  (in_ctrl),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_ctrl (out_ctrl),
      .cnt_clr  (cnt_clr),
      .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, compare against the model, advance the model across the edge.
   task automatic step(input logic iv, input logic [63:0] id, input logic [7:0] ic,
                       input logic ordy, input logic fl, input logic clr);
      bit   exp_rdy;
      ent_t e;
      in_valid  = iv;
      in_data   = id;
      in_ctrl   = ic;
      out_ready = ordy;
      flush     = fl;
      cnt_clr   = clr;
      #1;
      exp_rdy = !fl && ((mq.size() < CAP) || (CAP == 1 && ordy));
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      check("out_data", out_data, m_head);
      check("out_ctrl", 64'(out_ctrl), 64'((mq.size() > 0) ? mq[0].c : C_RST));
      check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      if (clr) m_cnt = 0;
      else if (mq.size() > 0 && !ordy && !fl && m_cnt < CNT_MAX) m_cnt++;
      if (fl) begin
         mq.delete();
      end else begin
         if (mq.size() > 0 && ordy) void'(mq.pop_front());
         if (iv && exp_rdy) begin
            e.d = id;
            e.c = ic;
            mq.push_back(e);
            n_acc++;
         end
      end
      if (mq.size() > 0) m_head = mq[0].d;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_ctrl   = '0;
      out_ready = 1'b0;
      cnt_clr   = 1'b0;
      #1;
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_ctrl", 64'(out_ctrl), 64'(C_RST));
      check("rst_data", out_data, 64'(0));
      check("rst_cnt", 64'(stall_cnt), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Streaming at full rate
      for (int i = 0; i < 100; i++) step(1'b1, 64'(i), 8'(i), 1'b1, 1'b0, 1'b0);
      #1;
      check("stream_last", out_data, 64'd99);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

      // Back-pressure: 5 stalled cycles with 3 entries offered, then drain
      n_acc = 0;
      for (int k = 0; k < 5; k++)
         step(n_acc < 3, 64'(100 + n_acc), 8'(8'h10 + n_acc), 1'b0, 1'b0, 1'b0);
      check("bp_held", 64'(n_acc), 64'(CAP));
      check("bp_stall", 64'(stall_cnt), 64'd4);
      for (int k = 0; k < 6; k++)
         step(n_acc < 3, 64'(100 + n_acc), 8'(8'h10 + n_acc), 1'b1, 1'b0, 1'b0);
      check("bp_all", 64'(n_acc), 64'd3);

      // Flush of a full stage while an entry is offered
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < CAP; k++) step(1'b1, 64'(200 + k), 8'hFF, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'hDEAD, 8'hFF, 1'b0, 1'b1, 1'b0);
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_ctrl", 64'(out_ctrl), 64'(C_RST));
      check("flush_data_held", out_data, 64'd200);
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("flush_rdy", 64'(in_ready), 64'd1);
      for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

      // Counter saturation and clear-over-increment
      step(1'b1, 64'd300, 8'h55, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 20; k++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("sat", 64'(stall_cnt), 64'd15);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      check("clr", 64'(stall_cnt), 64'd0);
      for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a stalled entry
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_ctrl", 64'(out_ctrl), 64'(C_RST));
      check("arst_data", out_data, 64'd0);
      check("arst_cnt", 64'(stall_cnt), 64'd0);
      mq.delete();
      m_cnt  = 0;
      m_head = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Random traffic with sparse flush and clear
      for (int i = 0; i < 10000; i++)
         step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom),
              1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0,
              $urandom_range(0, 99) == 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
